// File: rtl/mdu_controller_if.sv
// -----------------------------------------------------------------------------
// mdu_controller_if
// Request/response bundle between the core's main controller and the
// multiply/divide unit.
//
// Handshake: the master raises start for exactly one cycle while busy==0 and
// done==0. A start seen in any other cycle is dropped, not queued. The slave
// raises busy from the cycle after acceptance until the result is written.
// It then raises done (and divzero for a divide by zero) for one cycle. hi/lo
// are valid from the done cycle onward. mthi/mtlo are single-cycle writes that
// take effect only while the unit is idle and start is low.
//
// Signals:
//   start   - one-cycle operation request
//   op      - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srca    - multiplicand / dividend (rs)
//   srcb    - multiplier / divisor (rt)
//   mthi    - write wdata to hi
//   mtlo    - write wdata to lo
//   wdata   - MTHI/MTLO data
//   hi, lo  - architectural HI/LO registers
//   busy    - operation in progress
//   done    - one-cycle completion pulse
//   divzero - pulses with done when a divide had srcb==0
// -----------------------------------------------------------------------------
interface mdu_controller_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output start, op, srca, srcb, mthi, mtlo, wdata,
        input  hi, lo, busy, done, divzero
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo, wdata,
        output hi, lo, busy, done, divzero
    );
endinterface

// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
// Iterative multiply/divide unit with HI/LO registers. It executes MULT,
// MULTU, DIV, DIVU, MTHI and MTLO. One shared (WIDTH+2)-bit adder serves both
// shift-add multiply and restoring divide. Each iteration handles one bit per
// cycle on unsigned magnitudes. Signs are applied in a single FIX cycle.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-low reset
//   bus       - mdu_controller_if.slave (start/op/srca/srcb/mthi/mtlo/wdata in,
//               hi/lo/busy/done/divzero out)
//   state_dbg - current FSM state (IDLE=0, MUL=1, DIV=2, FIX=3, DONE=4)
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   When defined, a multiply leaves MUL as soon as the remaining multiplier
//   bits are zero. The accumulator is realigned by one final shift in FIX.
//   When undefined, every operation takes WIDTH+2 edges.
// -----------------------------------------------------------------------------
module mdu_controller #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mdu_controller_if.slave      bus,
    output logic [2:0]           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_mag;     // |multiplicand| or |dividend|
    logic [WIDTH-1:0]   b_mag;     // multiplier (shifts right) or divisor (fixed)
    logic [2*WIDTH-1:0] acc;       // {product} or {remainder, quotient}
    logic [CW-1:0]      cnt;       // completed iterations
    logic               is_div;
    logic               neg_res;   // operand signs differ
    logic               neg_rem;   // dividend was negative
    logic               dz;        // divide with srcb==0

    assign state_dbg = state;

    // Operand magnitudes at acceptance. Signed ops use two's-complement
    // magnitude. The most-negative value keeps its own bit pattern, and that
    // pattern reads correctly as an unsigned magnitude.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        sign_a = bus.op[0] & bus.srca[WIDTH-1];
        sign_b = bus.op[0] & bus.srcb[WIDTH-1];
        abs_a  = sign_a ? -bus.srca : bus.srca;
        abs_b  = sign_b ? -bus.srcb : bus.srcb;
    end

    // Shared adder.
    //   Multiply: upper accumulator half plus (multiplier LSB ? a : 0).
    //   Divide:   shifted partial remainder minus divisor. Bit WIDTH+1 set
    //             means the trial went negative, so the remainder is restored.
    logic [WIDTH+1:0] add_x, add_y, add_sum;

    always_comb begin
        add_x = '0;
        add_y = '0;
        if (is_div) begin
            add_x = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
            add_y = ~{2'b00, b_mag};
        end else begin
            add_x = {2'b00, acc[2*WIDTH-1:WIDTH]};
            add_y = b_mag[0] ? {2'b00, a_mag} : '0;
        end
        add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, is_div};
    end

    // Sign fix-up and result selection, written to hi/lo in FIX.
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
`ifdef MDU_EARLY_OUT_EN
        // After an early exit, the product still sits WIDTH-cnt places too high.
        prod = acc >> (CW'(WIDTH) - cnt);
`else
        prod = acc;
`endif
        prod_s = neg_res ? -prod : prod;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
        fix_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            // With divisor 0 every trial succeeds. The quotient is then all
            // ones, and the remainder is |srca|, so the dividend's sign returns
            // the original srca. lo is forced so that the quotient sign cannot
            // alter it.
            fix_lo = dz ? '1 : (neg_res ? -quo : quo);
            fix_hi = neg_rem ? -rem : rem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            hi_rst();
        end else begin
            bus.done    <= 1'b0;
            bus.divzero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        dz       <= bus.op[1] && (bus.srcb == '0);
                        a_mag    <= abs_a;
                        b_mag    <= abs_b;
                        acc      <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= bus.op[1] ? S_DIV : S_MUL;
`ifdef MDU_EARLY_OUT_EN
                        if (!bus.op[1] && bus.srcb == '0) state <= S_FIX;
`endif
                    end else begin
                        if (bus.mthi) bus.hi <= bus.wdata;
                        if (bus.mtlo) bus.lo <= bus.wdata;
                    end
                end
                S_MUL: begin
                    acc   <= {add_sum[WIDTH:0], acc[WIDTH-1:1]};
                    b_mag <= b_mag >> 1;
                    cnt   <= cnt + 1'b1;
`ifdef MDU_EARLY_OUT_EN
                    if (cnt == CW'(WIDTH-1) || (b_mag >> 1) == '0) state <= S_FIX;
`else
                    if (cnt == CW'(WIDTH-1)) state <= S_FIX;
`endif
                end
                S_DIV: begin
                    if (add_sum[WIDTH+1])
                        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    else
                        acc <= {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= S_FIX;
                end
                S_FIX: begin
                    bus.hi      <= fix_hi;
                    bus.lo      <= fix_lo;
                    bus.busy    <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.divzero <= dz;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset values for all registered state other than the FSM.
    task automatic hi_rst();
        bus.hi      <= '0;
        bus.lo      <= '0;
        bus.busy    <= 1'b0;
        bus.done    <= 1'b0;
        bus.divzero <= 1'b0;
        a_mag       <= '0;
        b_mag       <= '0;
        acc         <= '0;
        cnt         <= '0;
        is_div      <= 1'b0;
        neg_res     <= 1'b0;
        neg_rem     <= 1'b0;
        dz          <= 1'b0;
    endtask

endmodule

// File: tb/tb_mdu_controller.sv
// -----------------------------------------------------------------------------
// tb_mdu_controller
// Directed bench for mdu_controller (default build, fixed latency).
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mdu_controller;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // done seen after edge E(W+1)

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_controller_if #(.WIDTH(W)) bus();
    logic [2:0] state_dbg;

    mdu_controller #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // Issue one operation, then wait (bounded) for done. Expected hi/lo go
    // through exp_q. inject_e >= 0 raises start+mtlo after edge E(inject_e).
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz, input int inject_e);
        logic [W-1:0] hi0, lo0, xh, xl;
        int  e, done_e, busy_n;
        bit  stable;
        exp_q.push_back(eh);
        exp_q.push_back(el);
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        e = 0; done_e = -1; busy_n = 0; stable = 1'b1;
        while (e < LAT + 8 && done_e < 0) begin
            @(negedge clk);          // sample after edge E(e)
            bus.start = 1'b0;
            bus.mtlo  = 1'b0;
            if (bus.done) begin
                done_e = e;
            end else begin
                if (bus.busy) busy_n++;
                if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
            end
            if (e == inject_e) begin
                bus.start = 1'b1;
                bus.mtlo  = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
                bus.op    = 2'b10;
                bus.srca  = 32'h0000_0055;
                bus.srcb  = 32'h0000_0003;
            end
            e++;
        end
        xh = exp_q.pop_front();
        xl = exp_q.pop_front();
        check({tag, "_latency"}, 64'(done_e), 64'(LAT));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(LAT));
        check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi), 64'(xh));
        check({tag, "_lo"}, 64'(bus.lo), 64'(xl));
        check({tag, "_divzero"}, 64'(bus.divzero), 64'(edz));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_flags", {61'd0, bus.busy, bus.done, bus.divzero}, 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;

        // Multiply
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
        run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        run_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1);

        // Divide
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1);
        run_op("div_m7_2",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("divu_zero",  2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, -1);
        run_op("divu_9_3",   2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, -1);

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(bus.lo), 64'd3);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthilo_hi", 64'(bus.hi), 64'hA5A5_0F0F);
        check("mthilo_lo", 64'(bus.lo), 64'hA5A5_0F0F);

        // start + mtlo in the middle of a MULT are both ignored
        run_op("mult_inject", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5);

        // Asynchronous reset in the middle of a MULTU
        @(negedge clk);
        bus.op    = 2'b00;
        bus.srca  = 32'h0000_1234;
        bus.srcb  = 32'h0000_5678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_state", 64'(state_dbg), 64'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.done) saw_done = 1'b1;
            end
            reset = 1'b1;
            repeat (LAT + 2) begin
                @(negedge clk);
                if (bus.done) saw_done = 1'b1;
            end
            check("abort_no_done", 64'(saw_done), 64'd0);
        end
        run_op("multu_after_rst", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, -1);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
